// File: rtl/counter_limit_monitor.sv
// Counter limit monitor: flags over-limit, unexpected change and stall of an upstream counter.
// Optional stall detection is compiled in with `define CNT_MON_STALL_DET_EN.
module counter_limit_monitor #(
    parameter int unsigned LIMIT        = 100,
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned STALL_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] counter,
    input  logic             alarm_ack,
    output logic             alarm,
    output logic [1:0]       alarm_code,
    output logic [7:0]       viol_cnt,
    output logic [WIDTH-1:0] max_seen
);

    typedef enum logic [1:0] {IDLE, TRACK, ALARM} state_t;

    localparam logic [1:0] CODE_NONE  = 2'b00;
    localparam logic [1:0] CODE_OVER  = 2'b01;
    localparam logic [1:0] CODE_CHG   = 2'b10;
    localparam logic [1:0] CODE_STALL = 2'b11;

    state_t           state_q, state_nxt;
    logic [WIDTH-1:0] prev_q;
    logic             prev_vld_q;
    logic             prev_en_q;
    logic             over, chg, stall, viol;
    logic [1:0]       cause;

    assign over = 32'(counter) > 32'(LIMIT);
    // The previous sample is only trusted once one cycle has passed since reset.
    assign chg  = prev_vld_q && !prev_en_q && (counter != prev_q);

`ifdef CNT_MON_STALL_DET_EN
    localparam int unsigned RW = $clog2(STALL_CYCLES + 1);
    logic [RW-1:0] run_q, run_nxt;

    // Run length of enabled cycles holding the same value, including the first one.
    always_comb begin
        run_nxt = '0;
        if (enable) begin
            if (prev_vld_q && prev_en_q && (counter == prev_q))
                run_nxt = run_q + RW'(1);
            else
                run_nxt = RW'(1);
        end
    end

    assign stall = enable && (run_nxt == RW'(STALL_CYCLES));

    always_ff @(posedge clk) begin
        if (reset)      run_q <= '0;
        else if (stall) run_q <= '0;
        else            run_q <= run_nxt;
    end
`else
    logic unused_stall_cfg;
    assign unused_stall_cfg = (STALL_CYCLES == 0);
    assign stall            = 1'b0;
`endif

    always_comb begin
        cause = CODE_NONE;
        if (over)       cause = CODE_OVER;
        else if (chg)   cause = CODE_CHG;
        else if (stall) cause = CODE_STALL;
    end

    assign viol = (cause != CODE_NONE);

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        if (viol)
            state_nxt = ALARM;
        else if (state_q != ALARM || alarm_ack)
            state_nxt = enable ? TRACK : IDLE;
    end

    always_comb begin
        alarm = (state_q == ALARM);
    end

    // First cause sticks while in ALARM unless an ack arrives alongside a new violation.
    always_ff @(posedge clk) begin
        if (reset)
            alarm_code <= CODE_NONE;
        else if (viol && (state_q != ALARM || alarm_ack))
            alarm_code <= cause;
        else if (state_q == ALARM && alarm_ack)
            alarm_code <= CODE_NONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            viol_cnt   <= '0;
            max_seen   <= '0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            prev_en_q  <= 1'b0;
        end else begin
            if (viol && viol_cnt != 8'hFF)
                viol_cnt <= viol_cnt + 8'd1;
            if (counter > max_seen)
                max_seen <= counter;
            prev_q     <= counter;
            prev_vld_q <= 1'b1;
            prev_en_q  <= enable;
        end
    end

endmodule

// File: tb/tb_counter_limit_monitor.sv
// Randomized + directed bench for counter_limit_monitor against a behavioural model.
// Stall expectations follow `define CNT_MON_STALL_DET_EN, same as the design.
module tb_counter_limit_monitor;
    localparam int LIMIT = 100;
    localparam int STALL = 16;

    logic       clk = 1'b0;
    logic       reset, enable, alarm_ack;
    logic [7:0] counter;
    logic       alarm;
    logic [1:0] alarm_code;
    logic [7:0] viol_cnt, max_seen;

    int checks = 0;
    int errors = 0;

    // Reference state: what the outputs must be, plus the sample history the rules need.
    int m_alarm, m_code, m_cnt, m_max;
    int m_hist_val[$];
    int m_hist_en[$];
    int m_run_base;

    counter_limit_monitor #(.LIMIT(LIMIT), .WIDTH(8), .STALL_CYCLES(STALL)) dut (
        .clk(clk), .reset(reset), .enable(enable), .counter(counter),
        .alarm_ack(alarm_ack), .alarm(alarm), .alarm_code(alarm_code),
        .viol_cnt(viol_cnt), .max_seen(max_seen)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", tag, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus, advance the model, compare every output.
    task automatic step(input bit rst, input bit en, input int cnt, input bit ack);
        int  cause, n, run;
        bit  stall;
        reset = rst; enable = en; counter = 8'(cnt); alarm_ack = ack;
        @(posedge clk);
        if (rst) begin
            m_alarm = 0; m_code = 0; m_cnt = 0; m_max = 0;
            m_hist_val.delete(); m_hist_en.delete(); m_run_base = 0;
        end else begin
            n = m_hist_val.size();
            stall = 1'b0;
`ifdef CNT_MON_STALL_DET_EN
            // Count trailing enabled samples equal to cnt, since the last stall restart.
            run = 0;
            if (en) begin
                run = 1;
                for (int i = n - 1; i >= m_run_base; i--) begin
                    if (m_hist_en[i] == 1 && m_hist_val[i] == cnt) run++;
                    else break;
                end
            end
            stall = (run == STALL);
`else
            run = 0;
`endif
            cause = 0;
            if (cnt > LIMIT) cause = 1;
            else if (n > 0 && m_hist_en[n-1] == 0 && m_hist_val[n-1] != cnt) cause = 2;
            else if (stall) cause = 3;
            if (cause != 0) begin
                if (m_cnt < 255) m_cnt++;
                if (m_alarm == 0 || ack) m_code = cause;
                m_alarm = 1;
            end else if (m_alarm == 1 && ack) begin
                m_alarm = 0; m_code = 0;
            end
            if (cnt > m_max) m_max = cnt;
            m_hist_val.push_back(cnt);
            m_hist_en.push_back(int'(en));
            if (stall) m_run_base = m_hist_val.size();
        end
        #1;
        chk("alarm", int'(alarm), m_alarm);
        chk("alarm_code", int'(alarm_code), m_code);
        chk("viol_cnt", int'(viol_cnt), m_cnt);
        chk("max_seen", int'(max_seen), m_max);
    endtask

    initial begin
        int cur;
        reset = 1'b1; enable = 1'b0; counter = '0; alarm_ack = 1'b0;

        // Reset state
        step(1, 0, 0, 0);
        chk("rst_alarm", int'(alarm), 0);

        // Ramp 0..100 enabled: no alarm
        for (int i = 0; i <= 100; i++) step(0, 1, i, 0);
        chk("ramp_max", int'(max_seen), 100);
        chk("ramp_viol", int'(viol_cnt), 0);

        // Over-limit while enabled, then ack
        step(0, 1, 101, 0);
        chk("ovr_code", int'(alarm_code), 1);
        chk("ovr_cnt", int'(viol_cnt), 1);
        step(0, 1, 50, 1);
        chk("ack_clr", int'(alarm), 0);
        step(0, 1, 50, 1);

        // Disabled jump 40 -> 120: over-limit beats change
        step(1, 0, 0, 0);
        step(0, 0, 40, 0);
        step(0, 0, 40, 0);
        step(0, 0, 120, 0);
        chk("pri_code", int'(alarm_code), 1);
        chk("pri_cnt", int'(viol_cnt), 1);

        // Disabled 40 -> 60, then a second change during ALARM
        step(1, 0, 0, 0);
        step(0, 0, 40, 0);
        step(0, 0, 60, 0);
        chk("chg_code", int'(alarm_code), 2);
        step(0, 0, 70, 0);
        chk("chg_hold", int'(alarm_code), 2);
        chk("chg_cnt", int'(viol_cnt), 2);
        // ack coinciding with an over-limit takes the new cause
        step(0, 0, 110, 1);
        chk("ack_new", int'(alarm_code), 1);

        // Hold at 7 enabled for 16 cycles
        step(1, 0, 0, 0);
        step(0, 1, 3, 0);
        for (int i = 0; i < STALL; i++) step(0, 1, 7, 0);
`ifdef CNT_MON_STALL_DET_EN
        chk("stall_code", int'(alarm_code), 3);
`else
        chk("stall_none", int'(alarm), 0);
`endif

        // Saturation, then reset mid-ALARM overriding ack and violation
        step(1, 0, 0, 0);
        for (int i = 0; i < 300; i++) step(0, 1, 200, 0);
        chk("sat", int'(viol_cnt), 255);
        step(1, 1, 200, 1);
        chk("rst_alarm2", int'(alarm), 0);
        chk("rst_max", int'(max_seen), 0);

        // Random traffic
        cur = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 25) cur = $urandom_range(0, 110);
            step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7, cur,
                 $urandom_range(0, 9) < 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/counter_limit_monitor.md
COUNTER_LIMIT_MONITOR -- requirements
Module: counter_limit_monitor

Interface
REQ-001 The block SHALL have exactly one clock and one reset: reset is synchronous and active-high.
REQ-002 Parameter LIMIT SHALL default to 100 and give the maximum legal counter value.
REQ-003 Parameter WIDTH SHALL default to 8 and give the counter width.
REQ-004 Parameter STALL_CYCLES SHALL default to 16 and give the number of enabled cycles without change that counts as a stall.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 enable  input  1  upstream counter enable, sampled each cycle.
REQ-008 counter  input  WIDTH  upstream counter value, sampled each cycle.
REQ-009 alarm_ack  input  1  single-cycle acknowledge of a pending alarm.
REQ-010 alarm  output  1  high while a violation is latched.
REQ-011 alarm_code  output  2  latched cause: 00 none, 01 over-limit, 10 unexpected change, 11 stall.
REQ-012 viol_cnt  output  8  total violations detected, saturating.
REQ-013 max_seen  output  WIDTH  largest counter value sampled since reset.

Function
REQ-014 The FSM SHALL have three states: IDLE (enable low), TRACK (enable high), and ALARM (violation latched).
REQ-015 IDLE SHALL go to TRACK and TRACK SHALL go to IDLE on the sampled enable level when no violation is detected.
REQ-016 Over-limit SHALL be detected in any state when counter > LIMIT (unsigned compare).
REQ-017 Unexpected change SHALL be detected when enable was low in the previous cycle and counter differs from the previous sample.
REQ-018 Stall SHALL be detected when enable has been high for STALL_CYCLES consecutive cycles with counter unchanged; the stall run counter SHALL then restart.
REQ-019 No comparison against the previous sample SHALL occur in the first cycle after reset, because the previous sample is not yet valid.
REQ-020 When more than one violation occurs in the same cycle, priority SHALL be over-limit, then unexpected change, then stall; only one violation is counted per cycle.
REQ-021 A detected violation SHALL move the FSM to ALARM, set alarm and alarm_code on the next rising edge (1-cycle latency), and increment viol_cnt.
REQ-022 In ALARM, alarm_code SHALL hold the first cause; further violations SHALL increment viol_cnt only.
REQ-023 alarm_ack in ALARM SHALL clear alarm and alarm_code next cycle and return the FSM to TRACK or IDLE according to enable.
REQ-024 If alarm_ack coincides with a new violation, alarm SHALL stay high, alarm_code SHALL take the new cause, and viol_cnt SHALL increment.
REQ-025 alarm_ack outside ALARM SHALL be ignored.
REQ-026 viol_cnt SHALL saturate at 255 and never wrap.
REQ-027 max_seen SHALL update each cycle to max(max_seen, counter).

Reset
REQ-028 Reset SHALL put the FSM in IDLE and set alarm to 0, alarm_code to 00, viol_cnt to 0, max_seen to 0, the stall run counter to 0, and the previous-sample-valid flag to 0.
REQ-029 Reset asserted mid-ALARM SHALL override ack and violations in the same cycle.

Configuration
REQ-030 With CNT_MON_STALL_DET_EN defined, stall detection SHALL be present as described in REQ-018.
REQ-031 Without CNT_MON_STALL_DET_EN, the stall logic SHALL be absent, code 11 SHALL never be produced, and all other behaviour SHALL be unchanged.

Verification
REQ-032 Reset, then enable=1 and counter stepping 0..100 -> alarm stays 0, viol_cnt=0, max_seen=100.
REQ-033 Counter=101 while enabled -> next cycle alarm=1, alarm_code=01, viol_cnt=1; alarm_ack -> alarm=0 next cycle.
REQ-034 enable=0, counter forced from 40 to 120 -> alarm_code=01 (over-limit beats unexpected change), viol_cnt increments by 1.
REQ-035 enable=0, counter forced from 40 to 60 -> alarm_code=10; a second change during ALARM -> code stays 10, viol_cnt=2.
REQ-036 With CNT_MON_STALL_DET_EN defined: enable=1 and counter held at 7 for 16 cycles -> alarm_code=11; without the macro -> no alarm.
REQ-037 Inject 300 violations -> viol_cnt=255; assert reset during ALARM -> all outputs 0 next cycle.
